// File: rtl/lsu_dmem_responder.sv
// Data-memory responder for the core's LSU load/store handshake.
// Fixed-latency word-addressed memory with byte strobes and out-of-range flagging.
module lsu_dmem_responder #(
    parameter int ADDR_WIDTH_D = 10,
    parameter int WAIT_STATES  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rready_cpu,
    output logic        rvalid_cpu,
    input  logic        wvalid_cpu,
    output logic        wready_cpu,
    input  logic [3:0]  strb_cpu,
    input  logic [31:0] addr_cpu,
    input  logic [31:0] data_cpu_o,
    output logic [31:0] data_cpu_i,
    output logic        access_err
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH_D;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;

    logic        is_write;
    logic [31:2] addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic                    accept;
    logic                    do_access;
    logic                    acc_write;
    logic [31:2]             acc_addr;
    logic [31:0]             acc_data;
    logic [3:0]              acc_strb;
    logic                    in_range;
    logic [ADDR_WIDTH_D-1:0] index;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^addr_cpu[1:0];

    // With no wait states the access happens on the accept edge, so it must use the live inputs.
    always_comb begin
        accept    = (state == S_IDLE) && (wvalid_cpu || rready_cpu);
        acc_write = is_write;
        acc_addr  = addr_q;
        acc_data  = data_q;
        acc_strb  = strb_q;
        if (state == S_IDLE) begin
            acc_write = wvalid_cpu;
            acc_addr  = addr_cpu[31:2];
            acc_data  = data_cpu_o;
            acc_strb  = strb_cpu;
        end
        in_range  = (acc_addr >> ADDR_WIDTH_D) == 30'd0;
        index     = acc_addr[ADDR_WIDTH_D+1:2];
        do_access = (accept && (WAIT_STATES == 0)) || ((state == S_WAIT) && (wait_cnt == 4'd0));
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            is_write   <= 1'b0;
            addr_q     <= 30'd0;
            data_q     <= 32'd0;
            strb_q     <= 4'd0;
            err_q      <= 1'b0;
            data_cpu_i <= 32'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                is_write <= wvalid_cpu;
                addr_q   <= addr_cpu[31:2];
                data_q   <= data_cpu_o;
                strb_q   <= strb_cpu;
            end
            if (do_access) begin
                err_q <= !in_range;
                if (!acc_write) begin
                    data_cpu_i <= in_range ? mem[index] : 32'd0;
                end
            end
        end
    end

    // Memory has no reset; rst_n gating keeps a request held during reset from writing.
    always_ff @(posedge clk) begin
        if (rst_n && do_access && acc_write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_strb[i]) begin
                    mem[index][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

    assign rvalid_cpu = (state == S_RESP) && !is_write;
    assign wready_cpu = (state == S_RESP) && is_write;
    assign access_err = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// Directed bench for lsu_dmem_responder: one instance with no wait states, one with three.
module tb_lsu_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rready [2];
    logic        wvalid [2];
    logic [3:0]  strb   [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic        rvalid [2];
    logic        wready [2];
    logic        err    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_dmem_responder #(.ADDR_WIDTH_D(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .rready_cpu(rready[0]), .rvalid_cpu(rvalid[0]),
        .wvalid_cpu(wvalid[0]), .wready_cpu(wready[0]),
        .strb_cpu(strb[0]), .addr_cpu(addr[0]),
        .data_cpu_o(wdata[0]), .data_cpu_i(rdata[0]),
        .access_err(err[0])
    );

    lsu_dmem_responder #(.ADDR_WIDTH_D(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .rready_cpu(rready[1]), .rvalid_cpu(rvalid[1]),
        .wvalid_cpu(wvalid[1]), .wready_cpu(wready[1]),
        .strb_cpu(strb[1]), .addr_cpu(addr[1]),
        .data_cpu_o(wdata[1]), .data_cpu_i(rdata[1]),
        .access_err(err[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One full core-side transaction; latency is counted from the accept edge.
    task automatic applyStimulus(input int sel, input logic we, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s,
                                 output logic [31:0] rd, output logic e);
        int   lat;
        logic seen;
        logic other;
        @(negedge clk);
        addr[sel]  = a;
        wdata[sel] = d;
        strb[sel]  = s;
        if (we) wvalid[sel] = 1'b1;
        else    rready[sel] = 1'b1;
        @(posedge clk);
        lat   = 0;
        seen  = 1'b0;
        other = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen  = we ? wready[sel] : rvalid[sel];
            other = we ? rvalid[sel] : wready[sel];
        end
        wvalid[sel] = 1'b0;
        rready[sel] = 1'b0;
        rd = rdata[sel];
        e  = err[sel];
        checkOutput(we ? "write_latency" : "read_latency", 32'(lat), (sel == 0) ? 32'd1 : 32'd4);
        checkOutput("no_cross_pulse", 32'(other), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n1;
        int          n2;
        logic        any_pulse;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rready[i] = 1'b1;
            wvalid[i] = 1'b1;
            strb[i]   = 4'hF;
            addr[i]   = 32'h10;
            wdata[i]  = 32'hFFFF_FFFF;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_flags", {29'd0, rvalid[i], wready[i], err[i]}, 32'd0);
            checkOutput("reset_rdata", rdata[i], 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            rready[i] = 1'b0;
            wvalid[i] = 1'b0;
        end
        rst_n = 1'b1;
        any_pulse = 1'b0;
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) any_pulse |= rvalid[i] | wready[i] | err[i];
        end
        checkOutput("idle_no_pulse", 32'(any_pulse), 32'd0);

        $display("[TB] zero wait states: write/read and strobes");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e);
        checkOutput("wr_err", 32'(e), 32'd0);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
        checkOutput("rd_deadbeef", rd, 32'hDEADBEEF);
        checkOutput("rd_err", 32'(e), 32'd0);
        applyStimulus(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, e);
        applyStimulus(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, e);
        checkOutput("rd_strobe_merge", rd, 32'hDE22BE44);
        applyStimulus(0, 1'b1, 32'h14, 32'h77777777, 4'hF, rd, e);
        checkOutput("rdata_held_over_write", rdata[0], 32'hDE22BE44);
        applyStimulus(0, 1'b1, 32'h10, 32'h00000000, 4'h0, rd, e);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
        checkOutput("rd_after_zero_strobe", rd, 32'hDE22BE44);

        $display("[TB] out-of-range accesses");
        applyStimulus(0, 1'b1, 32'h0, 32'h5A5A1234, 4'hF, rd, e);
        applyStimulus(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, e);
        checkOutput("oor_wr_err", 32'(e), 32'd1);
        applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, e);
        checkOutput("oor_rd_err", 32'(e), 32'd1);
        checkOutput("oor_rd_data", rd, 32'h0);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, e);
        checkOutput("word0_intact", rd, 32'h5A5A1234);
        checkOutput("word0_err", 32'(e), 32'd0);

        $display("[TB] simultaneous write and read requests");
        @(negedge clk);
        addr[0]   = 32'h30;
        wdata[0]  = 32'hC0FFEE11;
        strb[0]   = 4'hF;
        wvalid[0] = 1'b1;
        rready[0] = 1'b1;
        n1 = 0;
        do begin
            @(negedge clk);
            n1++;
        end while (!wready[0] && n1 < 40);
        checkOutput("dual_write_first", 32'(n1), 32'd1);
        checkOutput("dual_no_rvalid_with_wready", 32'(rvalid[0]), 32'd0);
        wvalid[0] = 1'b0;
        n2 = 0;
        do begin
            @(negedge clk);
            n2++;
        end while (!rvalid[0] && n2 < 40);
        rready[0] = 1'b0;
        checkOutput("dual_read_delay", 32'(n2), 32'd2);
        checkOutput("dual_read_data", rdata[0], 32'hC0FFEE11);

        $display("[TB] three wait states: latency and throughput");
        applyStimulus(1, 1'b1, 32'h20, 32'hA5A50F0F, 4'hF, rd, e);
        applyStimulus(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, e);
        checkOutput("ws3_rd_data", rd, 32'hA5A50F0F);
        @(negedge clk);
        addr[1]   = 32'h20;
        rready[1] = 1'b1;
        n1 = 0;
        do begin
            @(negedge clk);
            n1++;
        end while (!rvalid[1] && n1 < 40);
        checkOutput("b2b_first_latency", 32'(n1), 32'd4);
        n2 = 0;
        do begin
            @(negedge clk);
            n2++;
        end while (!rvalid[1] && n2 < 40);
        rready[1] = 1'b0;
        checkOutput("b2b_pulse_spacing", 32'(n2), 32'd5);
        checkOutput("b2b_data", rdata[1], 32'hA5A50F0F);

        $display("[TB] reset during wait states");
        applyStimulus(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, e);
        @(negedge clk);
        addr[1]   = 32'h40;
        wdata[1]  = 32'h12345678;
        strb[1]   = 4'hF;
        wvalid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        wvalid[1] = 1'b0;
        #1;
        checkOutput("midreset_flags", {29'd0, rvalid[1], wready[1], err[1]}, 32'd0);
        checkOutput("midreset_rdata", rdata[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_pulse = 1'b0;
        repeat (8) begin
            @(negedge clk);
            any_pulse |= rvalid[1] | wready[1] | err[1];
        end
        checkOutput("midreset_no_pulse", 32'(any_pulse), 32'd0);
        applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, e);
        checkOutput("midreset_mem_intact", rd, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
